// File: rtl/adc_sequencer.sv
// ADC conversion sequencer: periodically pulses adc_go, collects each
// converter result into a first-word fall-through FIFO and keeps sticky
// overflow / timeout flags.
module adc_sequencer #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [15:0]              period,
    input  logic                     clr_err,
    output logic                     adc_go,
    input  logic                     adc_valid,
    input  logic [7:0]               adc_result,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [7:0]               out_data,
    output logic [$clog2(DEPTH):0]   fill,
    output logic                     overflow,
    output logic                     timeout_err
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, CONV, GAP} state_e;

    state_e          state_q, state_d;
    logic [15:0]     per_q, per_d, per_dec;
    logic [TW-1:0]   to_q, to_d;
    logic            go_q, go_d;
    logic            push_req, to_evt, gap_done, to_hit;

    logic [7:0]      mem_q [DEPTH];
    logic [AW-1:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic            ovf_q, ovf_d, toe_q, toe_d;
    logic            full, do_push, do_pop, drop;

    // Period counter saturates at zero; GAP exits when the decremented value
    // reaches zero so that start-to-start spacing equals period exactly.
    assign per_dec  = (per_q == '0) ? '0 : per_q - 16'd1;
    assign gap_done = (per_dec == '0);
    assign to_hit   = (to_q == TW'(TIMEOUT - 1));

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; enable has priority over result and timeout
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (enable) state_d = CONV;
            CONV: begin
                if (!enable)                  state_d = IDLE;
                else if (adc_valid || to_hit) state_d = GAP;
            end
            GAP: begin
                if (!enable)       state_d = IDLE;
                else if (gap_done) state_d = CONV;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: counter updates, push request, timeout event, go
    always_comb begin
        per_d    = per_q;
        to_d     = to_q;
        push_req = 1'b0;
        to_evt   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (enable) begin
                    per_d = period;
                    to_d  = '0;
                end
            end
            CONV: begin
                per_d = per_dec;
                to_d  = to_q + 1'b1;
                if (enable) begin
                    if (adc_valid)   push_req = 1'b1;
                    else if (to_hit) to_evt   = 1'b1;
                end
            end
            GAP: begin
                per_d = per_dec;
                if (enable && gap_done) begin
                    per_d = period;
                    to_d  = '0;
                end
            end
            default: ;
        endcase
        go_d = (state_d == CONV);
    end

    // Sequencer counters and registered converter go
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            per_q <= '0;
            to_q  <= '0;
            go_q  <= 1'b0;
        end else begin
            per_q <= per_d;
            to_q  <= to_d;
            go_q  <= go_d;
        end
    end

    // FIFO control: pop only when non-empty; a pop frees room for a push
    always_comb begin
        full    = (cnt_q == (AW + 1)'(DEPTH));
        do_pop  = (cnt_q != '0) && out_ready;
        do_push = push_req && (!full || do_pop);
        drop    = push_req && full && !do_pop;
        wptr_d  = do_push ? wptr_q + 1'b1 : wptr_q;
        rptr_d  = do_pop  ? rptr_q + 1'b1 : rptr_q;
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        // Set events win over a same-cycle clear
        ovf_d = drop   ? 1'b1 : (clr_err ? 1'b0 : ovf_q);
        toe_d = to_evt ? 1'b1 : (clr_err ? 1'b0 : toe_q);
    end

    // FIFO pointers, occupancy and sticky flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            toe_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            toe_q  <= toe_d;
        end
    end

    // FIFO storage; contents are don't-care while empty so no reset
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wptr_q] <= adc_result;
    end

    assign adc_go      = go_q;
    assign out_valid   = (cnt_q != '0);
    assign out_data    = mem_q[rptr_q];
    assign fill        = cnt_q;
    assign overflow    = ovf_q;
    assign timeout_err = toe_q;

endmodule

// File: tb/tb_adc_sequencer.sv
// Bench for adc_sequencer: randomized and directed stimulus, converter
// model, conversion-level reference model feeding a result scoreboard.
module tb_adc_sequencer;

    localparam int DEPTH = 4;
    localparam int TMO   = 32;
    localparam int NRES  = 4096;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b1;
    logic                   enable = 1'b0;
    logic [15:0]            period = '0;
    logic                   clr_err = 1'b0;
    logic                   adc_go;
    logic                   adc_valid = 1'b0;
    logic [7:0]             adc_result = '0;
    logic                   out_valid;
    logic                   out_ready = 1'b0;
    logic [7:0]             out_data;
    logic [$clog2(DEPTH):0] fill;
    logic                   overflow;
    logic                   timeout_err;

    adc_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (enable),
        .period     (period),
        .clr_err    (clr_err),
        .adc_go     (adc_go),
        .adc_valid  (adc_valid),
        .adc_result (adc_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .fill       (fill),
        .overflow   (overflow),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int        n_chk = 0;
    int        n_pass = 0;
    int        cyc = 0;

    // Per-conversion converter latency and result, indexed by conversion number
    int        lat [NRES];
    logic [7:0] res [NRES];

    function automatic void check(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endfunction

    // Converter model: result ready lat cycles after go rises, held while go
    int c_idx = -1;
    int gcnt  = 0;
    always begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            gcnt      = 0;
            adc_valid = 1'b0;
        end else begin
            #1;
            if (adc_go) begin
                gcnt++;
                if (gcnt == 1) c_idx++;
                adc_valid  = (gcnt >= lat[c_idx] + 1);
                adc_result = res[c_idx];
            end else begin
                gcnt      = 0;
                adc_valid = 1'b0;
            end
        end
    end

    // Reference model at conversion level: each conversion has a start cycle,
    // a go duration, a push-or-timeout outcome and a next start time.
    bit         m_run = 0;
    int         m_idx = -1;
    int         m_start = 0;
    int         m_dur = 0;
    int         m_L = 0;
    int         m_next = 0;
    bit         m_ovf = 0;
    bit         m_toe = 0;
    logic [7:0] sb_q [$];
    bit         mp_push, mp_tevt, mp_pop;
    logic [7:0] mp_val;

    function automatic void start_conv(input int p);
        m_run   = 1;
        m_idx++;
        m_start = cyc;
        m_L     = lat[m_idx];
        m_dur   = (m_L < TMO) ? m_L + 1 : TMO;
        m_next  = cyc + ((p > m_dur + 1) ? p : m_dur + 1);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_run = 0;
            m_ovf = 0;
            m_toe = 0;
            sb_q.delete();
        end else begin
            cyc++;
            mp_push = 0;
            mp_tevt = 0;
            mp_val  = '0;
            mp_pop  = (sb_q.size() > 0) && out_ready;
            if (!m_run) begin
                if (enable) start_conv(int'(period));
            end else if (!enable) begin
                m_run = 0;
            end else begin
                if (cyc == m_start + m_dur) begin
                    if (m_L < TMO) begin
                        mp_push = 1;
                        mp_val  = res[m_idx];
                    end else begin
                        mp_tevt = 1;
                    end
                end
                if (cyc == m_next) start_conv(int'(period));
            end
            if (mp_tevt) m_toe = 1;
            else if (clr_err) m_toe = 0;
            if (mp_push && sb_q.size() == DEPTH && !mp_pop) m_ovf = 1;
            else if (clr_err) m_ovf = 0;
            if (mp_pop) void'(sb_q.pop_front());
            if (mp_push && sb_q.size() < DEPTH) sb_q.push_back(mp_val);
        end
    end

    // Monitor: compares DUT outputs to the model every cycle, measures go pulses
    bit go_prev = 0;
    int rise_cyc = 0;
    int last_spacing = 0;
    int last_len = 0;
    bit exp_go;
    always @(negedge clk) begin
        if (rst_n) begin
            exp_go = m_run && (cyc >= m_start) && (cyc < m_start + m_dur);
            check("adc_go", int'(adc_go), int'(exp_go));
            check("fill", int'(fill), sb_q.size());
            check("out_valid", int'(out_valid), int'(sb_q.size() > 0));
            if (out_valid && sb_q.size() > 0) check("out_data", int'(out_data), int'(sb_q[0]));
            check("overflow", int'(overflow), int'(m_ovf));
            check("timeout_err", int'(timeout_err), int'(m_toe));
            if (adc_go && !go_prev) begin
                last_spacing = cyc - rise_cyc;
                rise_cyc     = cyc;
            end
            if (!adc_go && go_prev) last_len = cyc - rise_cyc;
            go_prev = adc_go;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Step until conversion idx has been running for off cycles
    task automatic wait_conv(input int idx, input int off, input string name);
        int n = 0;
        while (!(m_idx == idx && cyc == m_start + off) && n < 300) begin
            step();
            n++;
        end
        if (n >= 300) check(name, 0, 1);
    endtask

    task automatic drain();
        int n = 0;
        out_ready = 1'b1;
        while (sb_q.size() != 0 && n < 40) begin
            step();
            n++;
        end
        out_ready = 1'b0;
        if (n >= 40) check("drain_timeout", 0, 1);
    endtask

    int b;

    initial begin
        for (int i = 0; i < NRES; i++) begin
            lat[i] = $urandom_range(0, 40);
            res[i] = 8'($urandom);
        end

        // Reset state
        #1 rst_n = 1'b0;
        #3;
        check("rst_adc_go", int'(adc_go), 0);
        check("rst_fill", int'(fill), 0);
        check("rst_out_valid", int'(out_valid), 0);
        check("rst_overflow", int'(overflow), 0);
        check("rst_timeout_err", int'(timeout_err), 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        step();

        // Periodic conversions, period 20, latency 11, result A5
        b = m_idx + 1;
        for (int i = 0; i < 4; i++) begin
            lat[b + i] = 11;
            res[b + i] = 8'hA5;
        end
        period = 16'd20;
        enable = 1'b1;
        wait_conv(b, 12, "wait_first_result");
        check("p20_fill", int'(fill), 1);
        check("p20_out_valid", int'(out_valid), 1);
        check("p20_out_data", int'(out_data), 8'hA5);
        wait_conv(b + 2, 1, "wait_third_start");
        check("p20_spacing", last_spacing, 20);
        enable = 1'b0;
        step();
        drain();
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;

        // Back-to-back fill to overflow, then push+pop while full
        b = m_idx + 1;
        for (int i = 0; i < 6; i++) begin
            lat[b + i] = 2;
            res[b + i] = 8'(i + 1);
        end
        period = 16'd0;
        enable = 1'b1;
        wait_conv(b + 4, 3, "wait_fifth_result");
        check("full_fill", int'(fill), 4);
        check("full_head", int'(out_data), 8'h01);
        check("full_overflow", int'(overflow), 1);
        clr_err = 1'b1;
        step();
        clr_err = 1'b0;
        check("clr_overflow", int'(overflow), 0);
        wait_conv(b + 5, 2, "wait_sixth_push");
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("pushpop_fill", int'(fill), 4);
        check("pushpop_head", int'(out_data), 8'h02);
        check("pushpop_overflow", int'(overflow), 0);
        enable = 1'b0;
        step();
        drain();

        // Converter never answers: timeout after TMO cycles of go
        b = m_idx + 1;
        for (int i = 0; i < 3; i++) lat[b + i] = 99;
        enable = 1'b1;
        wait_conv(b + 1, 1, "wait_after_timeout");
        check("tmo_go_len", last_len, TMO);
        check("tmo_spacing", last_spacing, TMO + 1);
        check("tmo_flag", int'(timeout_err), 1);
        check("tmo_fill", int'(fill), 0);
        enable = 1'b0;
        step();

        // Enable dropped five cycles into a conversion
        b = m_idx + 1;
        lat[b] = 99;
        enable = 1'b1;
        wait_conv(b, 4, "wait_abort_point");
        enable = 1'b0;
        step();
        check("abort_go", int'(adc_go), 0);
        check("abort_fill", int'(fill), 0);
        step();
        check("abort_go_len", last_len, 5);

        // Asynchronous reset mid-conversion with two entries held
        b = m_idx + 1;
        for (int i = 0; i < 5; i++) lat[b + i] = 3;
        enable = 1'b1;
        wait_conv(b + 2, 1, "wait_reset_point");
        check("pre_rst_fill", int'(fill), 2);
        check("pre_rst_go", int'(adc_go), 1);
        check("pre_rst_tmo", int'(timeout_err), 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_go", int'(adc_go), 0);
        check("async_rst_fill", int'(fill), 0);
        check("async_rst_out_valid", int'(out_valid), 0);
        check("async_rst_overflow", int'(overflow), 0);
        check("async_rst_timeout_err", int'(timeout_err), 0);
        #3 rst_n = 1'b1;
        step();

        // Randomized operation: slow then fast downstream
        for (int i = 0; i < 1600; i++) begin
            out_ready = (i < 800) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
            if (enable) begin
                if ($urandom_range(0, 79) == 0) enable = 1'b0;
            end else if ($urandom_range(0, 4) == 0) begin
                enable = 1'b1;
            end
            period  = 16'($urandom_range(0, 30));
            clr_err = ($urandom_range(0, 24) == 0);
            step();
        end

        enable    = 1'b0;
        clr_err   = 1'b0;
        out_ready = 1'b1;
        repeat (20) step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
